// File: rtl/ofm_pkg.sv
// Shared definitions for the OFM write path.
// The packer and the AXI master both take their pixel and bus word widths
// from here, so the two sides always agree on the packed word format.
package ofm_pkg;

  localparam int OFM_DATA_WIDTH = 16;
  localparam int OFM_AXI_WIDTH  = 256;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH,
    DONE
  } ofm_pack_state_t;

endpackage

// File: rtl/ofm_packer_if.sv
// Pixel stream handshake between the CNN datapath and the OFM packer.
//   PIX_VALID : pixel valid (datapath -> packer)
//   PIX_DATA  : pixel value (datapath -> packer)
//   PIX_LAST  : final pixel of the layer, qualified by PIX_VALID
//   PIX_READY : packer can take a pixel this cycle (packer -> datapath)
// master = datapath side, slave = packer side.
interface ofm_packer_if #(
  parameter int DATA_WIDTH = ofm_pkg::OFM_DATA_WIDTH
);

  logic                  PIX_VALID;
  logic [DATA_WIDTH-1:0] PIX_DATA;
  logic                  PIX_LAST;
  logic                  PIX_READY;

  modport master (
    output PIX_VALID,
    output PIX_DATA,
    output PIX_LAST,
    input  PIX_READY
  );

  modport slave (
    input  PIX_VALID,
    input  PIX_DATA,
    input  PIX_LAST,
    output PIX_READY
  );

endinterface

// File: rtl/ofm_packer.sv
// OFM packer: gathers AXI_WIDTH/DATA_WIDTH consecutive pixels into one
// AXI-width word and writes it into the OFM FIFO with a one-cycle strobe.
// At end of layer any partial word is zero-padded and emitted, then
// DONE_PACK pulses.
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   START         : one-cycle layer start, honoured only in IDLE
//   pix           : pixel stream (slave side of ofm_packer_if)
//   FIFO_AFULL    : OFM FIFO almost-full, gates PIX_READY combinationally
//   WDATA_OUT     : packed word, held until the next emit
//   WRITE         : one-cycle FIFO write strobe
//   WORD_CNT      : words emitted since START (wraps)
//   BUSY          : FSM not in IDLE
//   DONE_PACK     : one-cycle pulse, the cycle after the final WRITE
module ofm_packer
  import ofm_pkg::*;
#(
  parameter int DATA_WIDTH = OFM_DATA_WIDTH,
  parameter int AXI_WIDTH  = OFM_AXI_WIDTH,
  parameter int WCNT_WIDTH = 20
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  START,
  ofm_packer_if.slave           pix,
  input  logic                  FIFO_AFULL,
  output logic [AXI_WIDTH-1:0]  WDATA_OUT,
  output logic                  WRITE,
  output logic [WCNT_WIDTH-1:0] WORD_CNT,
  output logic                  BUSY,
  output logic                  DONE_PACK
);

  localparam int LANES = AXI_WIDTH / DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  ofm_pack_state_t       state_q, state_d;
  logic [LW-1:0]         lane_cnt_q, lane_cnt_d;
  logic [AXI_WIDTH-1:0]  stage_q, stage_d;
  logic [AXI_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  done_q, done_d;
  logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  accept;

  assign pix.PIX_READY = (state_q == PACK) && !FIFO_AFULL;
  assign accept        = pix.PIX_VALID && pix.PIX_READY;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    stage_d    = stage_q;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    done_d     = 1'b0;
    wcnt_d     = wcnt_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = PACK;
          lane_cnt_d = '0;
          stage_d    = '0;
          wcnt_d     = '0;
        end
      end

      PACK: begin
        if (accept) begin
          stage_d[lane_cnt_q*DATA_WIDTH +: DATA_WIDTH] = pix.PIX_DATA;
          if (lane_cnt_q == LAST_LANE) begin
            // The word goes out including the pixel accepted this cycle,
            // so the staging register is released for the next word now.
            wdata_d    = stage_d;
            write_d    = 1'b1;
            wcnt_d     = wcnt_q + WCNT_WIDTH'(1);
            stage_d    = '0;
            lane_cnt_d = '0;
            if (pix.PIX_LAST) state_d = DONE;
          end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
            if (pix.PIX_LAST) state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // Unfilled lanes are already zero since the stage is cleared
        // on START and after every emit.
        if (!FIFO_AFULL) begin
          wdata_d    = stage_q;
          write_d    = 1'b1;
          wcnt_d     = wcnt_q + WCNT_WIDTH'(1);
          stage_d    = '0;
          lane_cnt_d = '0;
          state_d    = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      stage_q    <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      stage_q    <= stage_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign WDATA_OUT = wdata_q;
  assign WRITE     = write_q;
  assign WORD_CNT  = wcnt_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE_PACK = done_q;

endmodule

// File: tb/tb_ofm_packer.sv
module tb_ofm_packer;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         START = 1'b0;
  logic         FIFO_AFULL = 1'b0;
  logic [255:0] WDATA_OUT;
  logic         WRITE;
  logic [19:0]  WORD_CNT;
  logic         BUSY;
  logic         DONE_PACK;

  ofm_packer_if #(.DATA_WIDTH(16)) pif ();

  ofm_packer #(
    .DATA_WIDTH(16),
    .AXI_WIDTH (256),
    .WCNT_WIDTH(20)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .START     (START),
    .pix       (pif),
    .FIFO_AFULL(FIFO_AFULL),
    .WDATA_OUT (WDATA_OUT),
    .WRITE     (WRITE),
    .WORD_CNT  (WORD_CNT),
    .BUSY      (BUSY),
    .DONE_PACK (DONE_PACK)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare (every negedge) ----------
  logic [15:0]  m_pix[$];
  logic [255:0] m_wdata = '0;
  bit           m_write = 0, m_final = 0, m_done = 0;
  bit           m_busy = 0, m_pack = 0, m_flush = 0;
  int unsigned  m_cnt = 0;
  int           ncyc = 0;

  logic [255:0] wlog[$];
  int           wcyc[$];
  int           dcyc[$];

  function automatic logic [255:0] pack_q();
    logic [255:0] w = '0;
    foreach (m_pix[i]) w[i*16 +: 16] = m_pix[i];
    return w;
  endfunction

  always @(negedge ACLK) begin
    bit nw, nf, nd, nb, np, nfl;
    logic [255:0] nwd;
    int unsigned nc;
    ncyc++;
    if (!ARESETN) begin
      chk("rst_write", WRITE, 0);
      chk("rst_done", DONE_PACK, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ready", pif.PIX_READY, 0);
      chk("rst_wcnt", WORD_CNT, 0);
      chk("rst_wdata", WDATA_OUT, 0);
      m_pix.delete();
      m_wdata = '0; m_write = 0; m_final = 0; m_done = 0;
      m_busy = 0; m_pack = 0; m_flush = 0; m_cnt = 0;
    end else begin
      chk("write", WRITE, m_write);
      chk("wdata", WDATA_OUT, m_wdata);
      chk("done_pack", DONE_PACK, m_done);
      chk("word_cnt", WORD_CNT, m_cnt);
      chk("busy", BUSY, m_busy);
      chk("pix_ready", pif.PIX_READY, m_pack && !FIFO_AFULL);
      if (WRITE) begin wlog.push_back(WDATA_OUT); wcyc.push_back(ncyc); end
      if (DONE_PACK) dcyc.push_back(ncyc);

      nw = 0; nf = 0; nd = 0; nb = m_busy; np = m_pack; nfl = m_flush;
      nwd = m_wdata; nc = m_cnt;
      if (m_write && m_final) begin nd = 1; nb = 0; end
      if (START && !m_busy) begin nb = 1; np = 1; nc = 0; m_pix.delete(); end
      if (m_pack && pif.PIX_VALID && !FIFO_AFULL) begin
        m_pix.push_back(pif.PIX_DATA);
        if (m_pix.size() == 16) begin
          nwd = pack_q(); nw = 1; nf = pif.PIX_LAST;
          nc = (m_cnt + 1) % (1 << 20); m_pix.delete();
        end
        if (pif.PIX_LAST) begin np = 0; if (!nw) nfl = 1; end
      end
      if (m_flush && !FIFO_AFULL) begin
        nwd = pack_q(); nw = 1; nf = 1; nfl = 0;
        nc = (m_cnt + 1) % (1 << 20); m_pix.delete();
      end
      m_write = nw; m_final = nf; m_done = nd; m_busy = nb;
      m_pack = np; m_flush = nfl; m_wdata = nwd; m_cnt = nc;
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int bpa_s = 0, bpa_e = 0, bpb_s = 0, bpb_e = 0;

  task automatic tick();
    @(posedge ACLK);
    #1;
    cyc++;
    FIFO_AFULL = (cyc >= bpa_s && cyc < bpa_e) || (cyc >= bpb_s && cyc < bpb_e);
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Sends n pixels base..base+n-1; optional PIX_LAST on the final one and a
  // START pulse alongside pixel index start_at.
  task automatic send(input int n, input int base, input bit last, input int start_at);
    for (int i = 0; i < n; i++) begin
      bit acc = 0;
      int guard = 0;
      pif.PIX_VALID = 1'b1;
      pif.PIX_DATA  = 16'(base + i);
      pif.PIX_LAST  = last && (i == n - 1);
      if (i == start_at) START = 1'b1;
      while (!acc && guard < 50) begin
        @(negedge ACLK);
        acc = pif.PIX_READY;
        tick();
        START = 1'b0;
        guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    pif.PIX_VALID = 1'b0;
    pif.PIX_LAST  = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    int guard = 0;
    while (!got && guard < 200) begin
      @(negedge ACLK);
      if (DONE_PACK) got = 1;
      tick();
      guard++;
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); dcyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w;
    pif.PIX_VALID = 1'b0;
    pif.PIX_DATA  = '0;
    pif.PIX_LAST  = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
    tick();
    chk("idle_busy", BUSY, 0);

    // Full layer: 32 pixels 0..31
    clear_logs();
    do_start();
    send(32, 0, 1, -1);
    wait_done();
    chk("full_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      w = wlog[0];
      chk("full_w0_lane0", w[15:0], 16'd0);
      chk("full_w0_lane15", w[255:240], 16'd15);
      w = wlog[1];
      chk("full_w1_lane0", w[15:0], 16'd16);
      chk("full_spacing", wcyc[1] - wcyc[0], 16);
      chk("full_done_gap", (dcyc.size() == 1) ? dcyc[0] - wcyc[1] : -1, 1);
    end
    chk("full_wcnt", WORD_CNT, 2);

    // Partial flush: 20 pixels 1..20
    clear_logs();
    do_start();
    send(20, 1, 1, -1);
    wait_done();
    tick(); tick();
    chk("part_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      w = wlog[1];
      chk("part_w1_lo", w[63:0], 64'h0014_0013_0012_0011);
      chk("part_w1_pad", w[255:64], 192'd0);
    end
    chk("part_ndone", dcyc.size(), 1);
    chk("part_wcnt", WORD_CNT, 2);

    // Backpressure mid-word and during FLUSH
    clear_logs();
    do_start();
    bpa_s = cyc + 4;  bpa_e = cyc + 9;
    bpb_s = cyc + 25; bpb_e = cyc + 30;
    send(20, 100, 1, -1);
    wait_done();
    bpa_s = 0; bpa_e = 0; bpb_s = 0; bpb_e = 0;
    chk("bp_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      w = wlog[0];
      chk("bp_w0_lane0", w[15:0], 16'd100);
      chk("bp_w0_lane15", w[255:240], 16'd115);
      w = wlog[1];
      chk("bp_w1_lo", w[63:0], 64'h0077_0076_0075_0074);
    end
    chk("bp_ndone", dcyc.size(), 1);

    // Last pixel on lane 15
    clear_logs();
    do_start();
    send(16, 'h50, 1, -1);
    wait_done();
    tick(); tick();
    chk("l15_nwrites", wlog.size(), 1);
    if (wlog.size() == 1 && dcyc.size() == 1) begin
      w = wlog[0];
      chk("l15_lane15", w[255:240], 16'h5F);
      chk("l15_done_gap", dcyc[0] - wcyc[0], 1);
    end

    // START while busy (in PACK, then in DONE)
    clear_logs();
    do_start();
    send(32, 'h300, 1, 10);
    START = 1'b1;   // this cycle is the DONE state
    tick();
    START = 1'b0;
    tick(); tick();
    chk("sb_wcnt", WORD_CNT, 2);
    chk("sb_busy", BUSY, 0);
    chk("sb_nwrites", wlog.size(), 2);

    // Reset mid-word
    clear_logs();
    do_start();
    send(7, 'h100, 0, -1);
    ARESETN = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
    tick();
    chk("rm_nwrites", wlog.size(), 0);
    chk("rm_wcnt", WORD_CNT, 0);
    do_start();
    send(16, 'h200, 1, -1);
    wait_done();
    chk("rm_after_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      w = wlog[0];
      chk("rm_lane0", w[15:0], 16'h200);
      chk("rm_lane15", w[255:240], 16'h20F);
    end
    chk("rm_wcnt_after", WORD_CNT, 1);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
